digit_entry_ctrl: RTL
=====================

Name: digit_entry_ctrl

Overview:
- Upstream front-end for the 8-digit seven-segment display register file.
- Converts raw board inputs (write pushbutton, clear pushbutton, 4 hex switches) into the clean write/num/sel transaction stream the display block consumes.
- Synchronises and debounces the buttons, issues exactly one write per press, and auto-advances a digit cursor.
- The clear button sweeps 0 into every digit.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz).
- NUM_DIGITS, 8, number of display digits; cursor wraps modulo this value.
- SEL_W, 3, width of sel/cursor; must satisfy 2**SEL_W >= NUM_DIGITS.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- btn_write  input  1  raw write pushbutton, active-high, asynchronous to clk
- btn_clear  input  1  raw clear pushbutton, active-high, asynchronous to clk
- sw_num  input  4  raw hex value switches
- write  output  1  one-cycle write strobe to display block
- num  output  4  nibble to write, valid while write=1
- sel  output  SEL_W  digit index to write, valid while write=1
- cursor  output  SEL_W  next digit the write button will target (drives LEDs)
- busy  output  1  high while a write or clear sequence is in progress

Behaviour:
- Reset (reset=0, async): write=0, num=0, sel=0, cursor=0, busy=0, FSM=S_IDLE, debounce counters=0, debounced levels=0, synchroniser flops=0.
- Synchronisation: btn_write, btn_clear and sw_num each pass through 2 flops before any use.
- Debounce (per button): counter clears whenever the synced level equals the stable level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the stable level takes the synced level and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable level.
- Event: a 1-cycle pulse on a 0->1 transition of the stable level only; a release generates nothing. Holding a button produces exactly one event.
- FSM states:
  - S_IDLE: busy=0.
  - S_WRITE.
  - S_CLEAR (with clr_idx counter, SEL_W bits).
- S_IDLE, clear event -> S_CLEAR, clr_idx=0. Clear has priority when both events occur in the same cycle; that write event is discarded.
- S_IDLE, write event only -> S_WRITE; the synced sw_num is captured in the same cycle.
- S_WRITE (1 cycle): write=1, num=captured value, sel=cursor. Cursor then advances to cursor+1, wrapping NUM_DIGITS-1 -> 0. Return to S_IDLE.
- S_CLEAR (NUM_DIGITS cycles): each cycle write=1, num=0, sel=clr_idx, clr_idx increments. After the cycle with sel=NUM_DIGITS-1, cursor=0 and FSM returns to S_IDLE.
- All outputs are registered. write rises on the clock edge after the event cycle. write, num and sel change together.
- busy=1 exactly while in S_WRITE or S_CLEAR. Events arriving while busy=1 are dropped, not queued.
- sw_num changing after capture does not affect an in-flight write.
- Reset asserted mid-clear aborts the sweep immediately: write=0, cursor=0. No partial writes occur after reset release.
- Minimum press-to-write latency: 2 (sync) + DEBOUNCE_CYCLES (debounce) + 1 (event) + 1 (output register) cycles.

Decomposition:
- Package digit_entry_pkg: state enum (S_IDLE, S_WRITE, S_CLEAR), default NUM_DIGITS, SEL_W, DEBOUNCE_CYCLES constants.
- Sub-module button_debounce: 2-flop synchroniser, counter, stable level, and rising-edge pulse output. Instantiated once for btn_write and once for btn_clear.
- sw_num uses plain 2-flop synchronisers in the top level.

Test Plan (DEBOUNCE_CYCLES=4 in sim):
- Reset, sw_num=3, press btn_write 20 cycles -> exactly one write pulse with num=3, sel=0; then cursor=1, busy high for 1 cycle.
- Four presses with sw_num=3,6,9,C -> writes (3,sel0), (6,sel1), (9,sel2), (C,sel3); cursor=4.
- btn_write glitch high for 2 cycles -> no write, cursor unchanged.
- Nine presses with cursor starting at 0 -> the 9th write has sel=0 (wrap).
- Press btn_clear with cursor=5 -> 8 consecutive write cycles, num=0, sel=0..7; busy=1 for 8 cycles; cursor=0 at end. A btn_write press during the sweep is ignored.
- Both buttons pressed in the same cycle -> clear sweep only. Assert reset during the 3rd clear cycle -> write=0, cursor=0 immediately, and no writes follow.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// Shared types and default sizing for the digit entry front-end.
// Pulled in by the controller and its button debouncers.
package digit_entry_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_NUM_DIGITS      = 8;
    localparam int DEF_SEL_W           = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/digit_entry_ctrl_debounce.sv
// Synchronises one raw pushbutton, debounces it and emits a single-cycle
// pulse when the stable level rises.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    assign w_accept = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Only a newly accepted high level is an event; releases are silent.
            r_rise <= w_accept & r_sync2;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/digit_entry_ctrl.sv
// Turns raw write/clear buttons and hex switches into one-cycle display
// writes, with an auto-advancing cursor and a clear-all sweep.
module digit_entry_ctrl
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int NUM_DIGITS      = DEF_NUM_DIGITS,
    parameter int SEL_W           = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_write,
    input  logic             btn_clear,
    input  logic [3:0]       sw_num,
    output logic             write,
    output logic [3:0]       num,
    output logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] cursor,
    output logic             busy
);

    localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(NUM_DIGITS - 1);

    logic             w_write_evt;
    logic             w_clear_evt;

    logic [3:0]       r_sw_sync1;
    logic [3:0]       r_sw_sync2;

    state_t           r_state;
    logic             r_write;
    logic [3:0]       r_num;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_cursor;
    logic [SEL_W-1:0] r_clr_idx;
    logic             r_busy;

    state_t           w_state_next;
    logic             w_write_next;
    logic [3:0]       w_num_next;
    logic [SEL_W-1:0] w_sel_next;
    logic [SEL_W-1:0] w_cursor_next;
    logic [SEL_W-1:0] w_clr_idx_next;
    logic             w_busy_next;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_write_btn (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (btn_write),
        .o_rise (w_write_evt)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_btn (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (btn_clear),
        .o_rise (w_clear_evt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
        end else begin
            r_sw_sync1 <= sw_num;
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_num     <= '0;
            r_sel     <= '0;
            r_cursor  <= '0;
            r_clr_idx <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_write   <= w_write_next;
            r_num     <= w_num_next;
            r_sel     <= w_sel_next;
            r_cursor  <= w_cursor_next;
            r_clr_idx <= w_clr_idx_next;
            r_busy    <= w_busy_next;
        end
    end

    // Computes the values the output registers take at the next edge, so
    // write/num/sel/busy all change together on the edge after an event.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        w_state_next   = r_state;
        w_write_next   = 1'b0;
        w_num_next     = r_num;
        w_sel_next     = r_sel;
        w_cursor_next  = r_cursor;
        w_clr_idx_next = r_clr_idx;
        w_busy_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_clear_evt) begin
                    w_state_next   = S_CLEAR;
                    w_write_next   = 1'b1;
                    w_num_next     = '0;
                    w_sel_next     = '0;
                    w_clr_idx_next = '0;
                    w_busy_next    = 1'b1;
                end else if (w_write_evt) begin
                    w_state_next = S_WRITE;
                    w_write_next = 1'b1;
                    w_num_next   = r_sw_sync2;
                    w_sel_next   = r_cursor;
                    w_busy_next  = 1'b1;
                end
            end

            S_WRITE: begin
                w_state_next  = S_IDLE;
                w_cursor_next = (r_cursor == LAST_DIGIT) ? '0 : r_cursor + 1'b1;
            end

            S_CLEAR: begin
                if (r_clr_idx == LAST_DIGIT) begin
                    w_state_next   = S_IDLE;
                    w_cursor_next  = '0;
                    w_clr_idx_next = '0;
                end else begin
                    w_write_next   = 1'b1;
                    w_busy_next    = 1'b1;
                    w_clr_idx_next = r_clr_idx + 1'b1;
                    w_sel_next     = r_clr_idx + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign write  = r_write;
    assign num    = r_num;
    assign sel    = r_sel;
    assign cursor = r_cursor;
    assign busy   = r_busy;

endmodule
